// File: rtl/mcu_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mcu_pkg : opcode and controller state encodings shared by ALU users
// Rev 1.0
// ------------------------------------------------------------------
package mcu_pkg;

  localparam int OP_W = 4;
  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_ADD   = 4'd0;
  localparam op_t OP_SUB   = 4'd1;
  localparam op_t OP_MULT  = 4'd2;
  localparam op_t OP_DIV   = 4'd3;
  localparam op_t OP_OR    = 4'd4;
  localparam op_t OP_AND   = 4'd5;
  localparam op_t OP_XOR   = 4'd6;
  localparam op_t OP_READ  = 4'd7;
  localparam op_t OP_WRITE = 4'd8;
  localparam op_t OP_SHL   = 4'd9;
  localparam op_t OP_SHR   = 4'd10;
  localparam op_t OP_SAR   = 4'd11;
  localparam op_t OP_LAST  = OP_SAR;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_RD   = 3'd1;
  localparam state_t ST_RDW  = 3'd2;
  localparam state_t ST_EXEC = 3'd3;
  localparam state_t ST_WB   = 3'd4;
  localparam state_t ST_RSP  = 3'd5;

  function automatic logic op_is_valid(input op_t op);
    return (op <= OP_LAST);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_tmo_cnt.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_tmo_cnt : loadable down-counter, expired when it reaches zero
// Rev 1.0
// ------------------------------------------------------------------
module alu_tmo_cnt #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count   = r_count;
  assign expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/alu_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_ctrl : sequences memory-operand commands through an external ALU
// Rev 1.0
// ------------------------------------------------------------------
module alu_ctrl
  import mcu_pkg::*;
#(
  parameter int op_sz   = 32,
  parameter int addr_sz = 8,
  parameter int tmo_cyc = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_op,
  input  logic [op_sz-1:0]   cmd_data,
  input  logic [addr_sz-1:0] cmd_addr,
  input  logic               cmd_wb,
  output logic [addr_sz-1:0] mem_addr,
  output logic               mem_rd,
  input  logic [op_sz-1:0]   mem_rdata,
  output logic               mem_wr,
  output logic [op_sz-1:0]   mem_wdata,
  output logic [3:0]         alu_op,
  output logic [op_sz-1:0]   alu_in_1,
  output logic [op_sz-1:0]   alu_in_2,
  input  logic [op_sz-1:0]   alu_out,
  input  logic               alu_done,
  input  logic               alu_err,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [op_sz-1:0]   rsp_data,
  output logic               rsp_err
);

  localparam int c_cnt_w = $clog2(tmo_cyc + 1);
  // Counter holds this value during the first EXEC cycle and hits zero on the last.
  localparam logic [c_cnt_w-1:0] c_tmo_load = c_cnt_w'(tmo_cyc - 1);

  state_t             r_state;
  state_t             w_next;
  op_t                r_op;
  logic [op_sz-1:0]   r_data;
  logic [addr_sz-1:0] r_addr;
  logic               r_wb;
  logic [op_sz-1:0]   r_opnd;
  logic [op_sz-1:0]   r_result;
  logic               r_err;

  logic [c_cnt_w-1:0] w_count;
  logic               w_expired;
  logic               w_in_exec;
  logic               w_first;
  logic               w_alu_fin;
  logic               w_tmo;
  logic               w_div0;
  logic               w_accept;

  assign w_accept  = (r_state == ST_IDLE) && cmd_valid;
  assign w_in_exec = (r_state == ST_EXEC);
  assign w_first   = w_in_exec && (w_count == c_tmo_load);
  assign w_alu_fin = w_in_exec && !w_first && alu_done;
  assign w_tmo     = w_in_exec && w_expired;
  assign w_div0    = (r_op == OP_DIV) && (mem_rdata == '0);

  alu_tmo_cnt #(
    .CNT_W (c_cnt_w)
  ) u_tmo (
    .clk      (clk),
    .reset    (reset),
    .load     (r_state == ST_RDW),
    .load_val (c_tmo_load),
    .dec      (w_in_exec),
    .count    (w_count),
    .expired  (w_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (!op_is_valid(cmd_op)) begin
            w_next = ST_RSP;
          end else if (cmd_op == OP_WRITE) begin
            w_next = ST_WB;
          end else begin
            w_next = ST_RD;
          end
        end
      end
      ST_RD:   w_next = ST_RDW;
      ST_RDW: begin
        if ((r_op == OP_READ) || w_div0) begin
          w_next = ST_RSP;
        end else begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // A completion on the final cycle takes priority over the timeout.
        if (w_alu_fin) begin
          w_next = (r_wb && !alu_err) ? ST_WB : ST_RSP;
        end else if (w_tmo) begin
          w_next = ST_RSP;
        end
      end
      ST_WB:   w_next = ST_RSP;
      ST_RSP: begin
        if (rsp_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    mem_addr  = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    alu_op    = OP_ADD;
    alu_in_1  = '0;
    alu_in_2  = '0;
    rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: cmd_ready = 1'b1;
      ST_RD: begin
        mem_rd   = 1'b1;
        mem_addr = r_addr;
      end
      ST_EXEC: begin
        alu_op   = r_op;
        alu_in_1 = r_data;
        alu_in_2 = r_opnd;
      end
      ST_WB: begin
        mem_wr    = 1'b1;
        mem_addr  = r_addr;
        mem_wdata = r_result;
      end
      ST_RSP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op     <= OP_ADD;
      r_data   <= '0;
      r_addr   <= '0;
      r_wb     <= 1'b0;
      r_opnd   <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op     <= cmd_op;
            r_data   <= cmd_data;
            r_addr   <= cmd_addr;
            r_wb     <= cmd_wb;
            r_opnd   <= '0;
            r_result <= (cmd_op == OP_WRITE) ? cmd_data : '0;
            r_err    <= !op_is_valid(cmd_op);
          end
        end
        ST_RDW: begin
          r_opnd <= mem_rdata;
          if (r_op == OP_READ) begin
            r_result <= mem_rdata;
          end else if (w_div0) begin
            r_result <= '0;
            r_err    <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (w_alu_fin) begin
            r_result <= alu_out;
            r_err    <= alu_err;
          end else if (w_tmo) begin
            r_result <= '0;
            r_err    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_data = r_result;
  assign rsp_err  = r_err;

endmodule
`default_nettype wire

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter op_sz, default 32, operand/result width in bits.
REQ-002 Parameter addr_sz, default 8, memory address width in bits.
REQ-003 Parameter tmo_cyc, default 64, maximum EXEC cycles before timeout.
REQ-004 The block SHALL provide the following ports:
- clk, input, 1, single clock; all state on rising edge.
- reset, input, 1, asynchronous active-low reset.
- cmd_valid, input, 1, command offered.
- cmd_ready, output, 1, command accepted when high with cmd_valid.
- cmd_op, input, 4, opcode 0..11 (add, sub, mult, div, or, and, xor, read, write, shl, shr, sar).
- cmd_data, input, op_sz, immediate operand (ALU in_1).
- cmd_addr, input, addr_sz, memory operand/destination address.
- cmd_wb, input, 1, write ALU result back to cmd_addr.
- mem_addr, output, addr_sz, memory address.
- mem_rd, output, 1, read strobe; data valid exactly 1 cycle later.
- mem_rdata, input, op_sz, read data.
- mem_wr, output, 1, write strobe.
- mem_wdata, output, op_sz, write data.
- alu_op, output, 4, to ALU op.
- alu_in_1, output, op_sz, to ALU in_1.
- alu_in_2, output, op_sz, to ALU in_2.
- alu_out, input, op_sz, ALU result.
- alu_done, input, 1, ALU op_done.
- alu_err, input, 1, ALU op_err.
- rsp_valid, output, 1, response available.
- rsp_ready, input, 1, response consumed.
- rsp_data, output, op_sz, result.
- rsp_err, output, 1, error flag.

Function
REQ-005 FSM states SHALL be IDLE, RD, RDW, EXEC, WB, RSP; cmd_ready=1 only in IDLE.
REQ-006 On cmd_valid&&cmd_ready, the block SHALL register op/data/addr/wb and go to RD; opcode >11 SHALL instead go directly to RSP with rsp_err=1, rsp_data=0, no memory access.
REQ-007 write (8): IDLE->WB, mem_wr=1 for one cycle, mem_addr=cmd_addr, mem_wdata=cmd_data, then RSP with rsp_data=cmd_data.
REQ-008 All other valid ops: RD asserts mem_rd one cycle at cmd_addr; RDW captures mem_rdata into operand register.
REQ-009 read (7): RDW->RSP, rsp_data=captured memory word, ALU not used.
REQ-010 div (3) with memory operand 0: RDW->RSP, rsp_err=1, rsp_data=0, ALU not used.
REQ-011 EXEC: alu_op, alu_in_1=cmd_data, alu_in_2=memory operand SHALL be held constant every EXEC cycle.
REQ-012 alu_done/alu_err SHALL be ignored in the first EXEC cycle (settle) and sampled from the second; on alu_done=1 the block SHALL latch alu_out and alu_err.
REQ-013 If alu_done is not seen within tmo_cyc EXEC cycles, the block SHALL go to RSP with rsp_err=1, rsp_data=0.
REQ-014 After completion: if cmd_wb=1 and no error, EXEC->WB (mem_wr=1 at cmd_addr, data=result) ->RSP; else EXEC->RSP.
REQ-015 Outside EXEC, alu_op SHALL be 0 (add) and alu_in_1/alu_in_2 0, so multi-cycle units never start.
REQ-016 RSP: rsp_valid=1 with stable rsp_data/rsp_err until rsp_ready; on handshake ->IDLE, and cmd_ready rises next cycle (no same-cycle reaccept).
REQ-017 mem_rd and mem_wr SHALL never both be 1; each strobe SHALL last exactly one cycle.

Reset
REQ-018 reset=0 SHALL asynchronously force IDLE, timeout counter 0, all registered outputs 0 (cmd_ready=1 combinationally from IDLE).
REQ-019 Reset mid-operation SHALL abort it: no pending write, no response.

Structure
REQ-020 Opcode localparams (0..11) and the FSM state encoding SHALL live in a shared package, mcu_pkg, used also by the ALU.
REQ-021 One sub-module, alu_tmo_cnt (loadable down-counter with expiry flag), is natural; all else lives in alu_ctrl.

Verification
REQ-022 Scenario add: mem[5]=10, cmd op=0, data=3, addr=5, wb=1 -> rsp_data=13, rsp_err=0, mem[5]=13.
REQ-023 Scenario div0: mem[2]=0, op=3, data=7 -> rsp_err=1, rsp_data=0, alu_op stays 0.
REQ-024 Scenario mult: mem[1]=6, op=2, data=7, model ALU done after 20 cycles -> alu inputs stable all 20 cycles, rsp_data=42.
REQ-025 Scenario timeout: alu_done held 0, op=9 -> rsp_err=1 after exactly 64 EXEC cycles.
REQ-026 Scenario backpressure/invalid: op=13 with rsp_ready=0 for 5 cycles -> rsp_valid held, cmd_ready=0, no mem strobes, rsp_err=1.
REQ-027 Scenario reset: assert reset during EXEC of op=2 -> outputs 0 immediately, no mem_wr, no rsp_valid afterwards.
